mem_responder: RTL and testbench
================================

MEM_RESPONDER -- requirements
Module: mem_responder

Interface
REQ-001 SHALL have parameter DM_WORDS, default 3072, data RAM depth in 32-bit words.
REQ-002 SHALL have parameter TC_BASE, default 32'h0000_7F00, timer register base address.
REQ-003 SHALL have port clk  input  1  sole clock; all state updates on its rising edge.
REQ-004 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-005 SHALL have port m_data_addr  input  32  byte address from the processor memory stage.
REQ-006 SHALL have port m_data_wdata  input  32  write data, already byte-lane aligned.
REQ-007 SHALL have port m_data_byteen  input  4  per-byte write enables; 4'h0 means read or idle.
REQ-008 SHALL have port m_inst_addr  input  32  PC of the accessing instruction, for the write trace.
REQ-009 SHALL have port m_data_rdata  output  32  combinational read data for m_data_addr.
REQ-010 SHALL have port irq  output  1  timer interrupt request.

Function
REQ-011 SHALL decode word address addr[31:2]: RAM for 0 to 4*DM_WORDS-1; CTRL at TC_BASE, PRESET at TC_BASE+4, COUNT at TC_BASE+8; all else unmapped.
REQ-012 SHALL return RAM or timer contents on m_data_rdata in the same cycle; unmapped reads return 32'h0.
REQ-013 SHALL write each RAM byte lane i with wdata[8i+7:8i] at the clock edge when byteen[i]=1; the read in that cycle returns pre-write data.
REQ-014 SHALL accept timer writes only when byteen=4'hF; partial writes, COUNT writes and unmapped writes are ignored.
REQ-015 SHALL decode CTRL as bit0 EN, bits[2:1] MODE (00 one-shot, 01 auto-reload, 1x treated as 00), bit3 IM; bits[31:4] read 0.
REQ-016 SHALL run a timer FSM with states IDLE, LOAD, CNT, INT.
REQ-017 IDLE: SHALL go to LOAD when EN=1.
REQ-018 LOAD: SHALL copy PRESET into COUNT, then go to CNT.
REQ-019 CNT: EN=0 SHALL go to IDLE with COUNT held; COUNT=0 SHALL go to INT; otherwise COUNT SHALL decrement by 1.
REQ-020 INT, MODE 00: SHALL clear EN, set sticky irq flag, go to IDLE; flag SHALL clear on any accepted CTRL write.
REQ-021 INT, MODE 01: SHALL assert irq flag for that one cycle only, then go to LOAD.
REQ-022 irq SHALL equal IM AND irq flag, registered with no combinational path from inputs.
REQ-023 A CTRL write SHALL take priority over the FSM's own EN clear in the same cycle; a written EN=0 SHALL force IDLE on the next edge.
REQ-024 A PRESET write during CNT SHALL not alter COUNT until the next LOAD.
REQ-025 SHALL print one line "@%h: *%h <= %h" (PC, word address, merged word) per RAM write, via simulation display only.

Reset
REQ-026 On reset SHALL clear all RAM words, CTRL, PRESET, COUNT and irq flag to 0, force FSM to IDLE and drive irq=0 from the next cycle.
REQ-027 Reset during CNT or INT SHALL abort the count with no irq pulse.

Configuration
REQ-028 With macro MEM_RESPONDER_TIMER_EN defined SHALL include the timer per REQ-014..REQ-024.
REQ-029 Without MEM_RESPONDER_TIMER_EN SHALL treat timer addresses as unmapped and tie irq to 0.

Structure
REQ-030 Address map constants, CTRL field positions and FSM state encodings SHALL live in the shared defines package.
REQ-031 The timer SHALL be a separate sub-module named tc_timer; RAM and decode stay in mem_responder.

Verification
REQ-032 Write 32'h1234_5678 to 0x0000_0010 byteen=F, then byteen=4'b0010 wdata=32'h0000_AB00 -> read 0x10 returns 32'h1234_AB78.
REQ-033 Read 0x0000_3000 and 0x0000_7F0C -> rdata=0; write to them -> no RAM word changes.
REQ-034 PRESET=5, CTRL=32'h9 (EN, one-shot, IM) -> COUNT 5,4,3,2,1,0, INT; irq high and held; CTRL reads 32'h8; write CTRL=0 -> irq low next cycle.
REQ-035 PRESET=2, CTRL=32'hB (auto-reload, IM) -> irq one-cycle pulse every 5 cycles (LOAD, 3 CNT, INT); CTRL=32'h3 -> irq never asserts.
REQ-036 Reset asserted mid-CNT with COUNT=3 -> next cycle COUNT=0, CTRL=0, irq=0, all RAM reads 0.
REQ-037 Build without MEM_RESPONDER_TIMER_EN, write 32'h1 to TC_BASE -> reads 0, irq stays 0.

Source files
------------

// File: rtl/mem_responder_pkg.sv
// Shared address map, CTRL field layout and timer FSM encoding for mem_responder.
// The timer is only built when MEM_RESPONDER_TIMER_EN is defined.
package mem_responder_pkg;

    localparam int          DM_WORDS_DEFAULT = 3072;
    localparam logic [31:0] TC_BASE_DEFAULT  = 32'h0000_7F00;

    // Timer register offsets in 32-bit words from TC_BASE.
    localparam logic [29:0] TC_CTRL_WOFS   = 30'd0;
    localparam logic [29:0] TC_PRESET_WOFS = 30'd1;
    localparam logic [29:0] TC_COUNT_WOFS  = 30'd2;

    localparam int CTRL_EN       = 0;
    localparam int CTRL_MODE_LSB = 1;
    localparam int CTRL_MODE_MSB = 2;
    localparam int CTRL_IM       = 3;

    localparam logic [1:0] TC_MODE_ONESHOT = 2'b00;
    localparam logic [1:0] TC_MODE_AUTO    = 2'b01;

    typedef enum logic [1:0] {
        TC_IDLE = 2'd0,
        TC_LOAD = 2'd1,
        TC_CNT  = 2'd2,
        TC_INT  = 2'd3
    } tc_state_e;

    function automatic logic [31:0] lane_mask(input logic [3:0] be);
        return {{8{be[3]}}, {8{be[2]}}, {8{be[1]}}, {8{be[0]}}};
    endfunction

endpackage

// File: rtl/mem_responder_if.sv
// Processor data-memory port: single-cycle bus with no handshake. The master
// presents address/data/byte enables; the slave answers combinationally on rdata.
interface mem_responder_if;

    logic [31:0] m_data_addr;
    logic [31:0] m_data_wdata;
    logic [3:0]  m_data_byteen;
    logic [31:0] m_inst_addr;
    logic [31:0] m_data_rdata;

    modport master (
        output m_data_addr,
        output m_data_wdata,
        output m_data_byteen,
        output m_inst_addr,
        input  m_data_rdata
    );

    modport slave (
        input  m_data_addr,
        input  m_data_wdata,
        input  m_data_byteen,
        input  m_inst_addr,
        output m_data_rdata
    );

endinterface

// File: rtl/mem_responder_tc_timer.sv
// tc_timer: down-counting timer with one-shot / auto-reload modes and a masked irq.
// Instantiated by mem_responder only when MEM_RESPONDER_TIMER_EN is defined.
module tc_timer
    import mem_responder_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        wr_ctrl,
    input  logic        wr_preset,
    input  logic [31:0] wdata,
    output logic [31:0] ctrl_word,
    output logic [31:0] preset_word,
    output logic [31:0] count_word,
    output logic        irq,
    output tc_state_e   state_dbg
);

    tc_state_e   state, state_n;
    logic        en, en_n;
    logic [1:0]  mode;
    logic        im;
    logic [31:0] preset;
    logic [31:0] count, count_n;
    logic        sticky, sticky_n;
    logic        pulse, pulse_n;

    always_ff @(posedge clk) begin
        if (reset) begin
            state  <= TC_IDLE;
            en     <= 1'b0;
            mode   <= TC_MODE_ONESHOT;
            im     <= 1'b0;
            preset <= '0;
            count  <= '0;
            sticky <= 1'b0;
            pulse  <= 1'b0;
        end else begin
            state  <= state_n;
            en     <= en_n;
            count  <= count_n;
            sticky <= sticky_n;
            pulse  <= pulse_n;
            if (wr_ctrl) begin
                mode <= wdata[CTRL_MODE_MSB:CTRL_MODE_LSB];
                im   <= wdata[CTRL_IM];
            end
            if (wr_preset) begin
                preset <= wdata;
            end
        end
    end

    always_comb begin
        state_n  = state;
        en_n     = en;
        count_n  = count;
        sticky_n = sticky;
        pulse_n  = 1'b0;
        case (state)
            TC_IDLE: if (en) state_n = TC_LOAD;
            TC_LOAD: begin
                count_n = preset;
                state_n = TC_CNT;
            end
            TC_CNT: begin
                if (!en)                 state_n = TC_IDLE;
                else if (count == '0)    state_n = TC_INT;
                else                     count_n = count - 32'd1;
            end
            TC_INT: begin
                // Mode 1x behaves as one-shot; only 01 reloads.
                if (mode == TC_MODE_AUTO) begin
                    pulse_n = 1'b1;
                    state_n = TC_LOAD;
                end else begin
                    en_n     = 1'b0;
                    sticky_n = 1'b1;
                    state_n  = TC_IDLE;
                end
            end
            default: state_n = TC_IDLE;
        endcase
        // A software CTRL write overrides whatever the FSM decided this cycle.
        if (wr_ctrl) begin
            en_n     = wdata[CTRL_EN];
            sticky_n = 1'b0;
            pulse_n  = 1'b0;
            if (!wdata[CTRL_EN]) state_n = TC_IDLE;
        end
    end

    assign ctrl_word   = {28'd0, im, mode, en};
    assign preset_word = preset;
    assign count_word  = count;
    assign irq         = im & (sticky | pulse);
    assign state_dbg   = state;

endmodule

// File: rtl/mem_responder.sv
// mem_responder: byte-writable data RAM plus memory-mapped timer behind one bus.
// Define MEM_RESPONDER_TIMER_EN to build the timer; otherwise its addresses are unmapped.
module mem_responder
    import mem_responder_pkg::*;
#(
    parameter int          DM_WORDS = DM_WORDS_DEFAULT,
    parameter logic [31:0] TC_BASE  = TC_BASE_DEFAULT
) (
    input  logic             clk,
    input  logic             reset,
    mem_responder_if.slave   bus,
    output logic             irq
);

    localparam int          AW       = (DM_WORDS > 1) ? $clog2(DM_WORDS) : 1;
    localparam logic [29:0] DM_LIMIT = 30'(DM_WORDS);

    logic [31:0] mem [DM_WORDS];
    logic [29:0] word;
    logic [AW-1:0] ram_idx;
    logic        ram_hit;
    logic        ram_we;
    logic [31:0] ram_old;
    logic [31:0] ram_merged;
    logic [31:0] mask;
    logic        unused_ok;

    assign word       = bus.m_data_addr[31:2];
    assign ram_hit    = (word < DM_LIMIT);
    assign ram_idx    = word[AW-1:0];
    assign ram_we     = ram_hit && (bus.m_data_byteen != 4'h0);
    assign ram_old    = mem[ram_idx];
    assign mask       = lane_mask(bus.m_data_byteen);
    assign ram_merged = (ram_old & ~mask) | (bus.m_data_wdata & mask);

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < DM_WORDS; i++) begin
                mem[i] <= '0;
            end
        end else if (ram_we) begin
            mem[ram_idx] <= ram_merged;
        end
    end

`ifndef SYNTHESIS
    always_ff @(posedge clk) begin
        if (!reset && ram_we) begin
            $display("@%h: *%h <= %h", bus.m_inst_addr, {word, 2'b00}, ram_merged);
        end
    end
`endif

`ifdef MEM_RESPONDER_TIMER_EN
    localparam logic [29:0] TC_WORD = TC_BASE[31:2];

    logic        full_word;
    logic        wr_ctrl;
    logic        wr_preset;
    logic [31:0] ctrl_word;
    logic [31:0] preset_word;
    logic [31:0] count_word;
    tc_state_e   tc_state_dbg;

    // Timer registers only accept whole-word stores; COUNT is read-only.
    assign full_word = (bus.m_data_byteen == 4'hF);
    assign wr_ctrl   = full_word && !ram_hit && (word == TC_WORD + TC_CTRL_WOFS);
    assign wr_preset = full_word && !ram_hit && (word == TC_WORD + TC_PRESET_WOFS);

    tc_timer u_tc_timer (
        .clk         (clk),
        .reset       (reset),
        .wr_ctrl     (wr_ctrl),
        .wr_preset   (wr_preset),
        .wdata       (bus.m_data_wdata),
        .ctrl_word   (ctrl_word),
        .preset_word (preset_word),
        .count_word  (count_word),
        .irq         (irq),
        .state_dbg   (tc_state_dbg)
    );

    assign unused_ok = ^{bus.m_data_addr[1:0], tc_state_dbg};
`else
    assign irq       = 1'b0;
    assign unused_ok = ^bus.m_data_addr[1:0];
`endif

    always_comb begin
        bus.m_data_rdata = '0;
        if (ram_hit) begin
            bus.m_data_rdata = ram_old;
        end
`ifdef MEM_RESPONDER_TIMER_EN
        else if (word == TC_WORD + TC_CTRL_WOFS) begin
            bus.m_data_rdata = ctrl_word;
        end else if (word == TC_WORD + TC_PRESET_WOFS) begin
            bus.m_data_rdata = preset_word;
        end else if (word == TC_WORD + TC_COUNT_WOFS) begin
            bus.m_data_rdata = count_word;
        end
`endif
    end

endmodule

// File: tb/tb_mem_responder.sv
// Directed self-checking bench for mem_responder; timer checks are built when
// MEM_RESPONDER_TIMER_EN is defined, unmapped-timer checks otherwise.
module tb_mem_responder;

    localparam logic [31:0] TC      = 32'h0000_7F00;
    localparam logic [31:0] RAM_END = 32'h0000_3000;

    logic clk = 1'b0;
    logic reset;
    logic irq;

    mem_responder_if bus ();

    mem_responder #(.DM_WORDS(3072), .TC_BASE(TC)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus),
        .irq   (irq)
    );

    always #5 clk = ~clk;

    logic [31:0] exp_q[$];
    logic [31:0] ram_model [int unsigned];
    int n_cmp  = 0;
    int n_fail = 0;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs);
        logic [31:0] exp;
        n_cmp++;
        if (exp_q.size() == 0) begin
            n_fail++;
            $error("FAIL %s: observed %h with nothing expected", tag, obs);
            return;
        end
        exp = exp_q.pop_front();
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] model_rd(input logic [31:0] a);
        if (a < RAM_END && ram_model.exists(a >> 2)) return ram_model[a >> 2];
        return 32'h0;
    endfunction

    task automatic bus_write(input logic [31:0] addr, input logic [31:0] data,
                             input logic [3:0] be);
        logic [31:0] m;
        bus.m_data_addr   = addr;
        bus.m_data_wdata  = data;
        bus.m_data_byteen = be;
        bus.m_inst_addr   = 32'h0000_3000 + addr;
        #1;
        if (addr < RAM_END) begin
            for (int i = 0; i < 4; i++) m[8*i +: 8] = be[i] ? 8'hFF : 8'h00;
            ram_model[addr >> 2] = (model_rd(addr) & ~m) | (data & m);
        end
        tick();
        bus.m_data_byteen = 4'h0;
    endtask

    task automatic read_check(input string tag, input logic [31:0] addr,
                              input logic [31:0] exp);
        bus.m_data_addr   = addr;
        bus.m_data_byteen = 4'h0;
        #1;
        exp_q.push_back(exp);
        check(tag, bus.m_data_rdata);
    endtask

    task automatic read_ram(input string tag, input logic [31:0] addr);
        read_check(tag, addr, model_rd(addr));
    endtask

    task automatic irq_check(input string tag, input logic e);
        exp_q.push_back({31'd0, e});
        check(tag, {31'd0, irq});
    endtask

    initial begin
        reset             = 1'b1;
        bus.m_data_addr   = '0;
        bus.m_data_wdata  = '0;
        bus.m_data_byteen = 4'h0;
        bus.m_inst_addr   = '0;
        repeat (3) tick();
        reset = 1'b0;

        // Reset state
        read_ram("reset_ram_10", 32'h10);
        irq_check("reset_irq", 1'b0);

        // Full write then single-lane merge; read in the write cycle sees old data
        bus_write(32'h10, 32'h1234_5678, 4'hF);
        bus.m_data_addr   = 32'h10;
        bus.m_data_wdata  = 32'h0000_AB00;
        bus.m_data_byteen = 4'b0010;
        #1;
        exp_q.push_back(32'h1234_5678);
        check("prewrite_read", bus.m_data_rdata);
        bus_write(32'h10, 32'h0000_AB00, 4'b0010);
        read_check("lane_merge", 32'h10, 32'h1234_AB78);
        read_ram("lane_merge_model", 32'h10);

        // Last RAM word and a top-lane write
        bus_write(32'h2FFC, 32'hCAFE_F00D, 4'hF);
        read_ram("last_word", 32'h2FFC);
        bus_write(32'h0, 32'hA5C3_E1F0, 4'b1000);
        read_check("top_lane", 32'h0, 32'hA500_0000);
        bus_write(32'h4, 32'h1122_3344, 4'b0101);
        read_ram("mixed_lanes", 32'h4);

        // Unmapped addresses read zero and writes land nowhere
        read_check("unmapped_3000", 32'h3000, 32'h0);
        read_check("unmapped_7f0c", 32'h7F0C, 32'h0);
        bus_write(32'h3000, 32'hFFFF_FFFF, 4'hF);
        bus_write(32'h7F0C, 32'hFFFF_FFFF, 4'hF);
        read_check("unmapped_3000_after", 32'h3000, 32'h0);
        read_check("unmapped_7f0c_after", 32'h7F0C, 32'h0);
        read_ram("keep_word0", 32'h0);
        read_ram("keep_word10", 32'h10);
        read_ram("keep_last", 32'h2FFC);

`ifdef MEM_RESPONDER_TIMER_EN
        // Only full-word writes to CTRL/PRESET are accepted; COUNT is read-only
        bus_write(TC, 32'h9, 4'b0111);
        read_check("ctrl_partial", TC, 32'h0);
        bus_write(TC + 4, 32'h5, 4'b1110);
        read_check("preset_partial", TC + 4, 32'h0);
        bus_write(TC + 8, 32'h7, 4'hF);
        read_check("count_ro", TC + 8, 32'h0);

        // One-shot with interrupt enabled
        bus_write(TC + 4, 32'h5, 4'hF);
        bus_write(TC, 32'h9, 4'hF);
        bus.m_data_addr = TC + 8;
        tick();
        for (int k = 5; k >= 0; k--) begin
            tick();
            read_check("oneshot_count", TC + 8, 32'(k));
            irq_check("oneshot_irq_low", 1'b0);
        end
        tick();
        irq_check("oneshot_int_state", 1'b0);
        tick();
        irq_check("oneshot_irq_set", 1'b1);
        read_check("oneshot_ctrl_en_clr", TC, 32'h8);
        read_check("oneshot_preset", TC + 4, 32'h5);
        repeat (3) begin
            tick();
            irq_check("oneshot_irq_held", 1'b1);
        end
        bus_write(TC, 32'h0, 4'hF);
        irq_check("oneshot_irq_cleared", 1'b0);

        // Auto-reload: LOAD, 3 x CNT, INT -> one-cycle pulse every 5 cycles
        bus_write(TC + 4, 32'h2, 4'hF);
        bus_write(TC, 32'hB, 4'hF);
        for (int c = 1; c <= 16; c++) begin
            tick();
            irq_check("auto_irq", (c >= 6) && ((c - 6) % 5 == 0));
        end
        bus_write(TC, 32'h3, 4'hF);
        for (int c = 0; c < 12; c++) begin
            tick();
            irq_check("auto_masked_irq", 1'b0);
        end
        bus_write(TC, 32'h0, 4'hF);

        // Bring COUNT to 3 before the mid-count reset below
        bus_write(TC + 4, 32'h5, 4'hF);
        bus_write(TC, 32'h9, 4'hF);
        repeat (4) tick();
        read_check("pre_reset_count", TC + 8, 32'h3);
`else
        // Timer absent: its addresses are unmapped and irq is tied low
        bus_write(TC, 32'h1, 4'hF);
        read_check("notimer_ctrl", TC, 32'h0);
        bus_write(TC + 4, 32'h5, 4'hF);
        read_check("notimer_preset", TC + 4, 32'h0);
        for (int c = 0; c < 10; c++) begin
            tick();
            irq_check("notimer_irq", 1'b0);
        end
`endif

        // Synchronous reset mid-activity
        reset = 1'b1;
        tick();
        reset = 1'b0;
        ram_model.delete();
        irq_check("post_reset_irq", 1'b0);
        read_ram("post_reset_word0", 32'h0);
        read_ram("post_reset_word10", 32'h10);
        read_ram("post_reset_last", 32'h2FFC);
`ifdef MEM_RESPONDER_TIMER_EN
        read_check("post_reset_count", TC + 8, 32'h0);
        read_check("post_reset_ctrl", TC, 32'h0);
        read_check("post_reset_preset", TC + 4, 32'h0);
`endif
        for (int c = 0; c < 12; c++) begin
            tick();
            irq_check("post_reset_no_pulse", 1'b0);
        end

        if (exp_q.size() != 0) begin
            n_fail++;
            $error("FAIL leftover_expected: observed %0d queued expected 0", exp_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
